// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched instruction and PC for decode, with
// stall/flush handling, fetch-address fault detection and a stall watchdog.
module if_id_reg #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          IM_WORDS  = 1024,
  parameter int          MAX_STALL = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_F,
  input  logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic [4:0]  exc_D,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
  output logic        stall_timeout
);

  localparam int          RL_W   = $clog2(MAX_STALL) + 1;
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(MAX_STALL);
  // Range end computed in 33 bits so a fetch window touching 2^32 cannot wrap.
  localparam logic [32:0] PC_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);
  localparam logic [4:0]  EXC_NONE = 5'd0;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef enum logic {RUN, STALLED} wd_state_t;

  wd_state_t       state, state_nxt;
  logic [RL_W-1:0] rl, rl_nxt;
  logic            timeout_nxt;
  logic            fetch_fault;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign fetch_fault = (pc_F[1:0] != 2'b00)
                    || ({1'b0, pc_F} < {1'b0, RESET_PC})
                    || ({1'b0, pc_F} >= PC_END);

  // F -> D register stage
  always_ff @(posedge clk) begin
    if (clr) begin
      instr_D    <= 32'h0;
      pc_D       <= RESET_PC;
      pc8_D      <= RESET_PC + 32'd8;
      valid_D    <= 1'b0;
      exc_D      <= EXC_NONE;
      stall_cnt  <= 32'h0;
      bubble_cnt <= 32'h0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (flush) begin
      instr_D    <= 32'h0;
      pc_D       <= pc_F;
      pc8_D      <= pc_F + 32'd8;
      valid_D    <= 1'b0;
      exc_D      <= EXC_NONE;
      bubble_cnt <= sat_inc(bubble_cnt);
    end else begin
      pc_D    <= pc_F;
      pc8_D   <= pc_F + 32'd8;
      valid_D <= 1'b1;
      // A faulting fetch becomes a NOP but keeps its PC so EPC can be recovered.
      instr_D <= fetch_fault ? 32'h0 : instr_F;
      exc_D   <= fetch_fault ? EXC_ADEL : EXC_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= RUN;
      rl            <= '0;
      stall_timeout <= 1'b0;
    end else begin
      state         <= state_nxt;
      rl            <= rl_nxt;
      stall_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rl_nxt      = rl;
    timeout_nxt = stall_timeout;
    case (state)
      RUN: begin
        if (stall) begin
          state_nxt = STALLED;
          rl_nxt    = RL_W'(1);
        end else begin
          rl_nxt    = '0;
        end
      end
      STALLED: begin
        if (stall) begin
          rl_nxt = (rl >= RL_MAX) ? rl : rl + RL_W'(1);
        end else begin
          state_nxt = RUN;
          rl_nxt    = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        rl_nxt    = '0;
      end
    endcase
    if (state_nxt == STALLED && rl_nxt == RL_MAX)
      timeout_nxt = 1'b1;
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, load, stall, flush, fetch faults, watchdog.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        clr, stall, flush;
  logic [31:0] instr_F, pc_F;
  logic [31:0] instr_D, pc_D, pc8_D, stall_cnt, bubble_cnt;
  logic        valid_D, stall_timeout;
  logic [4:0]  exc_D;

  int total = 0;
  int bad   = 0;

  if_id_reg dut (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush),
    .instr_F(instr_F), .pc_F(pc_F),
    .instr_D(instr_D), .pc_D(pc_D), .pc8_D(pc8_D), .valid_D(valid_D),
    .exc_D(exc_D), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1; stall = 1'b0; flush = 1'b0; instr_F = 32'h0; pc_F = 32'h0;
    step();
    clr = 1'b0;
    chk("rst_instr", instr_D, 32'h0);
    chk("rst_pc", pc_D, 32'h3000);
    chk("rst_pc8", pc8_D, 32'h3008);
    chk("rst_valid", 32'(valid_D), 32'h0);
    chk("rst_exc", 32'(exc_D), 32'h0);
    chk("rst_scnt", stall_cnt, 32'h0);
    chk("rst_bcnt", bubble_cnt, 32'h0);
    chk("rst_tmo", 32'(stall_timeout), 32'h0);

    // normal load
    pc_F = 32'h3004; instr_F = 32'h3C01_1234;
    step();
    chk("ld_instr", instr_D, 32'h3C01_1234);
    chk("ld_pc", pc_D, 32'h3004);
    chk("ld_pc8", pc8_D, 32'h300C);
    chk("ld_valid", 32'(valid_D), 32'h1);
    chk("ld_exc", 32'(exc_D), 32'h0);

    // three-cycle stall holds D contents
    stall = 1'b1; pc_F = 32'h3008; instr_F = 32'h2000_0001;
    repeat (3) step();
    chk("st_pc", pc_D, 32'h3004);
    chk("st_instr", instr_D, 32'h3C01_1234);
    chk("st_scnt", stall_cnt, 32'd3);
    stall = 1'b0;
    step();
    chk("st_rel_pc", pc_D, 32'h3008);
    chk("st_rel_instr", instr_D, 32'h2000_0001);
    chk("st_rel_tmo", 32'(stall_timeout), 32'h0);

    // flush inserts a bubble carrying the next PC
    flush = 1'b1; pc_F = 32'h3010; instr_F = 32'h1111_1111;
    step();
    chk("fl_instr", instr_D, 32'h0);
    chk("fl_valid", 32'(valid_D), 32'h0);
    chk("fl_pc", pc_D, 32'h3010);
    chk("fl_pc8", pc8_D, 32'h3018);
    chk("fl_bcnt", bubble_cnt, 32'd1);

    // stall overrides flush
    stall = 1'b1; pc_F = 32'h3014;
    step();
    chk("sf_pc", pc_D, 32'h3010);
    chk("sf_bcnt", bubble_cnt, 32'd1);
    chk("sf_scnt", stall_cnt, 32'd4);
    chk("sf_valid", 32'(valid_D), 32'h0);
    stall = 1'b0; flush = 1'b0;

    // fetch faults
    instr_F = 32'hFFFF_FFFF;
    pc_F = 32'h3002;
    step();
    chk("mis_exc", 32'(exc_D), 32'd4);
    chk("mis_instr", instr_D, 32'h0);
    chk("mis_valid", 32'(valid_D), 32'h1);
    chk("mis_pc", pc_D, 32'h3002);
    pc_F = 32'h2FFC;
    step();
    chk("lo_exc", 32'(exc_D), 32'd4);
    chk("lo_instr", instr_D, 32'h0);
    chk("lo_pc", pc_D, 32'h2FFC);
    pc_F = 32'h4000;
    step();
    chk("hi_exc", 32'(exc_D), 32'd4);
    chk("hi_instr", instr_D, 32'h0);
    chk("hi_valid", 32'(valid_D), 32'h1);
    chk("hi_pc", pc_D, 32'h4000);
    pc_F = 32'h3FFC; instr_F = 32'h0C00_0C00;
    step();
    chk("top_exc", 32'(exc_D), 32'd0);
    chk("top_instr", instr_D, 32'h0C00_0C00);
    pc_F = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc8", pc8_D, 32'h0000_0004);
    chk("wrap_exc", 32'(exc_D), 32'd4);

    // 15-cycle stall: no timeout
    stall = 1'b1;
    repeat (15) step();
    chk("wd15_tmo", 32'(stall_timeout), 32'h0);
    chk("wd15_scnt", stall_cnt, 32'd19);
    stall = 1'b0;
    step();
    chk("wd15_rel_tmo", 32'(stall_timeout), 32'h0);

    // 16-cycle stall: timeout on the 16th edge, sticky
    stall = 1'b1;
    repeat (15) step();
    chk("wd16_pre_tmo", 32'(stall_timeout), 32'h0);
    step();
    chk("wd16_tmo", 32'(stall_timeout), 32'h1);
    stall = 1'b0;
    step();
    chk("wd16_sticky", 32'(stall_timeout), 32'h1);
    chk("wd16_scnt", stall_cnt, 32'd35);

    // reset mid-stall/flush wins
    clr = 1'b1; stall = 1'b1; flush = 1'b1;
    step();
    clr = 1'b0; stall = 1'b0; flush = 1'b0;
    chk("clr2_tmo", 32'(stall_timeout), 32'h0);
    chk("clr2_pc", pc_D, 32'h3000);
    chk("clr2_valid", 32'(valid_D), 32'h0);
    chk("clr2_scnt", stall_cnt, 32'h0);
    chk("clr2_bcnt", bubble_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
IF/ID pipeline register of the P5 pipelined MIPS core. It sits directly downstream of the PC register and instruction memory. It captures the fetched instruction and its PC each cycle and presents them to the decode stage. It also handles stall, flush, fetch-address exceptions, and keeps pipeline occupancy counters plus a stall watchdog for debug.

Parameters:
RESET_PC, 32'h0000_3000, PC value presented on pc_D after reset
IM_WORDS, 1024, instruction memory depth in words; the legal fetch range is [RESET_PC, RESET_PC+4*IM_WORDS)
MAX_STALL, 16, number of consecutive stall cycles after which stall_timeout sets

Ports:
clk  in  1  system clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
stall  in  1  hazard unit freeze; hold D-stage contents
flush  in  1  replace D-stage contents with a bubble
instr_F  in  32  instruction from IM for pc_F
pc_F  in  32  PC_now of the PC register
instr_D  out  32  instruction to decode
pc_D  out  32  PC of instr_D
pc8_D  out  32  pc_D+8, the jal/jalr link value
valid_D  out  1  1 = instr_D is a real instruction, 0 = bubble
exc_D  out  5  ExcCode: 0 none, 4 AdEL (fetch address fault)
stall_cnt  out  32  number of cycles with stall applied
bubble_cnt  out  32  number of cycles a bubble was loaded
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Update priority each rising edge: clr > stall > flush > normal load.
- clr: instr_D=0, pc_D=RESET_PC, pc8_D=RESET_PC+8, valid_D=0, exc_D=0, stall_cnt=0, bubble_cnt=0, stall_timeout=0, run-length counter=0, FSM=RUN.
- Normal load (no stall, no flush):
  - pc_D<=pc_F, pc8_D<=pc_F+8 (mod 2^32), valid_D<=1.
  - Fetch fault when pc_F[1:0]!=0, or pc_F<RESET_PC, or pc_F>=RESET_PC+4*IM_WORDS.
  - On a fault: exc_D<=4 and instr_D<=32'h0 (NOP). pc_D still holds the faulting pc_F, for EPC.
  - Without a fault: instr_D<=instr_F, exc_D<=0.
- Flush (without stall):
  - instr_D<=0, valid_D<=0, exc_D<=0.
  - pc_D<=pc_F and pc8_D<=pc_F+8, so the bubble carries the next PC for EPC/BD tracking.
  - bubble_cnt increments.
- Stall: all D outputs hold. stall_cnt increments. This applies with or without flush; flush is ignored while stalled and must be reasserted by the hazard logic.
- Latency: one cycle. Outputs reflect the inputs sampled at the previous edge. No combinational path from inputs to outputs.
- Counters: stall_cnt and bubble_cnt saturate at 32'hFFFF_FFFF (no wrap).
- Watchdog FSM, states RUN and STALLED, with an internal run-length counter rl (width clog2(MAX_STALL)+1):
  - RUN, stall=1: go to STALLED, rl=1.
  - RUN, stall=0: stay in RUN, rl=0.
  - STALLED, stall=1: rl increments, saturating at MAX_STALL.
  - STALLED, rl reaches MAX_STALL: stall_timeout<=1 on that edge.
  - STALLED, stall=0: go to RUN, rl=0.
  - stall_timeout clears only on clr.
- Reset mid-stall or mid-flush: clr wins outright. Next cycle is a bubble at RESET_PC.
- pc8_D wrap: pc_F=32'hFFFF_FFFC gives pc8_D=32'h0000_0004 (with exc_D=4, being out of range).

Test Plan:
- clr=1 for one edge, then release -> instr_D=0, pc_D=32'h3000, pc8_D=32'h3008, valid_D=0, counters 0, stall_timeout=0.
- pc_F=32'h3004, instr_F=32'h3C01_1234, no stall/flush -> next edge: instr_D=32'h3C01_1234, pc_D=32'h3004, pc8_D=32'h300C, valid_D=1, exc_D=0.
- After loading 32'h3004, assert stall for 3 cycles while pc_F changes to 32'h3008 -> D holds the 32'h3004 contents, stall_cnt=3. Then release -> pc_D=32'h3008.
- flush=1 with pc_F=32'h3010 -> instr_D=0, valid_D=0, pc_D=32'h3010, bubble_cnt=1. stall=1 and flush=1 together -> outputs hold, bubble_cnt unchanged, stall_cnt+1.
- pc_F=32'h3002, then pc_F=32'h2FFC, then pc_F=32'h4000 (IM_WORDS=1024) -> each gives exc_D=4, instr_D=0, valid_D=1, pc_D equal to the faulting PC.
- stall held 16 cycles -> stall_timeout=1 on the 16th edge; stays 1 after stall drops; clr -> 0. stall held 15 cycles -> stall_timeout stays 0.
